// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper sequencer: mode and state encodings,
// the eight-entry coil phase table and the index helper functions.
package stepper_pkg;

    localparam logic [1:0] MODE_WAVE = 2'b00;
    localparam logic [1:0] MODE_FULL = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Coil patterns indexed 0..7; even entries are single-coil, odd are two-coil.
    localparam logic [3:0] PHASE_0 = 4'b1000;
    localparam logic [3:0] PHASE_1 = 4'b1100;
    localparam logic [3:0] PHASE_2 = 4'b0100;
    localparam logic [3:0] PHASE_3 = 4'b0110;
    localparam logic [3:0] PHASE_4 = 4'b0010;
    localparam logic [3:0] PHASE_5 = 4'b0011;
    localparam logic [3:0] PHASE_6 = 4'b0001;
    localparam logic [3:0] PHASE_7 = 4'b1001;

    localparam logic [3:0] RESET_PATTERN = PHASE_0;

    // Snap the index onto the sub-table a mode uses: even for wave, odd for
    // full (mode 11 behaves as full), untouched for half-step.
    function automatic logic [2:0] align_idx(input logic [2:0] idx, input logic [1:0] mode);
        logic [2:0] r;
        case (mode)
            MODE_WAVE: r = {idx[2:1], 1'b0};
            MODE_HALF: r = idx;
            default:   r = {idx[2:1], 1'b1};
        endcase
        return r;
    endfunction

    // Advance the index one step; 3-bit arithmetic gives the modulo-8 wrap.
    function automatic logic [2:0] step_idx(input logic [2:0] idx, input logic [1:0] mode,
                                            input logic dir);
        logic [2:0] inc;
        inc = (mode == MODE_HALF) ? 3'd1 : 3'd2;
        return dir ? (idx + inc) : (idx - inc);
    endfunction

endpackage

// File: rtl/stepper_phase_lut.sv
// Combinational phase index to coil pattern lookup.
module stepper_phase_lut
    import stepper_pkg::*;
(
    input  logic [2:0] idx,
    output logic [3:0] pattern
);

    // Straight table decode of the phase index.
    always_comb begin
        pattern = RESET_PATTERN;
        case (idx)
            3'd0: pattern = PHASE_0;
            3'd1: pattern = PHASE_1;
            3'd2: pattern = PHASE_2;
            3'd3: pattern = PHASE_3;
            3'd4: pattern = PHASE_4;
            3'd5: pattern = PHASE_5;
            3'd6: pattern = PHASE_6;
            3'd7: pattern = PHASE_7;
            default: pattern = RESET_PATTERN;
        endcase
    end

endmodule

// File: rtl/stepper_seq_ctrl.sv
// Stepper move sequencer: wave / full / half-step coil drive, programmable
// step rate, commanded step count, signed position tracking and a
// start/busy/done handshake.
module stepper_seq_ctrl
    import stepper_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DIV_W = 8
) (
    input  logic             drv_clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] nsteps,
    input  logic [DIV_W-1:0] rate_div,
    input  logic             abort,
    output logic [3:0]       motor_drv,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pos
);

    state_t           state;
    logic [2:0]       idx;
    logic [CNT_W-1:0] remaining;
    logic [DIV_W-1:0] presc;
    logic             dir_q;
    logic [1:0]       mode_q;
    logic [DIV_W-1:0] rate_q;

    logic             accept;
    logic             step_fire;
    logic [2:0]       idx_nxt;
    logic [3:0]       pattern_nxt;

    // Decide the next phase index: alignment on an accepted start, a step
    // when the prescaler expires in RUN (abort suppresses it), else hold.
    always_comb begin
        accept    = (state == ST_IDLE) && start;
        step_fire = (state == ST_RUN) && !abort && (presc == '0);
        idx_nxt   = idx;
        if (accept)
            idx_nxt = align_idx(idx, mode);
        else if (step_fire)
            idx_nxt = step_idx(idx, mode_q, dir_q);
    end

    stepper_phase_lut u_lut (
        .idx     (idx_nxt),
        .pattern (pattern_nxt)
    );

    // Move FSM; every output is registered so the coil drive never glitches.
    always_ff @(posedge drv_clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= 3'd0;
            motor_drv <= RESET_PATTERN;
            busy      <= 1'b0;
            done      <= 1'b0;
            pos       <= '0;
            remaining <= '0;
            presc     <= '0;
            dir_q     <= 1'b0;
            mode_q    <= MODE_WAVE;
            rate_q    <= '0;
        end else begin
            done      <= 1'b0;
            idx       <= idx_nxt;
            motor_drv <= pattern_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dir_q  <= dir;
                        mode_q <= mode;
                        rate_q <= rate_div;
                        if (nsteps == '0) begin
                            // Zero-length move finishes immediately without busy.
                            done <= 1'b1;
                        end else begin
                            remaining <= nsteps;
                            presc     <= rate_div;
                            busy      <= 1'b1;
                            state     <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        remaining <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (presc == '0) begin
                        pos       <= dir_q ? (pos + CNT_W'(1)) : (pos - CNT_W'(1));
                        remaining <= remaining - CNT_W'(1);
                        presc     <= rate_q;
                        if (remaining == CNT_W'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end else begin
                        presc <= presc - DIV_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Self-checking bench for stepper_seq_ctrl. Two instances share stimulus:
// default widths and CNT_W=4 (the latter exercises position wrap).
module tb_stepper_seq_ctrl;

    logic        drv_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        start   = 1'b0;
    logic        dir     = 1'b0;
    logic [1:0]  mode    = 2'b00;
    logic [15:0] nsteps  = '0;
    logic [7:0]  rate_div = '0;
    logic        abort   = 1'b0;

    logic [3:0]  motor_drv, motor_drv4;
    logic        busy, busy4, done, done4;
    logic [15:0] pos;
    logic [3:0]  pos4;

    int total = 0;
    int bad   = 0;

    always #5 drv_clk = ~drv_clk;

    stepper_seq_ctrl dut (
        .drv_clk(drv_clk), .reset(reset), .start(start), .dir(dir), .mode(mode),
        .nsteps(nsteps), .rate_div(rate_div), .abort(abort),
        .motor_drv(motor_drv), .busy(busy), .done(done), .pos(pos)
    );

    stepper_seq_ctrl #(.CNT_W(4), .DIV_W(8)) dut4 (
        .drv_clk(drv_clk), .reset(reset), .start(start), .dir(dir), .mode(mode),
        .nsteps(nsteps[3:0]), .rate_div(rate_div), .abort(abort),
        .motor_drv(motor_drv4), .busy(busy4), .done(done4), .pos(pos4)
    );

    // Reference model: a move is a schedule of nsteps steps at E0+k*(rate+1).
    logic [3:0]  phase_tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                   4'b0010, 4'b0011, 4'b0001, 4'b1001};
    int          m_idx = 0;
    logic [15:0] m_pos = '0;
    bit          m_busy = 0, m_done = 0, m_dir = 0, m_half = 0;
    longint      m_cyc = 0, m_t0 = 0;
    int          m_rate = 0, m_n = 0, m_k = 0;

    always @(posedge drv_clk or posedge reset) begin
        if (reset) begin
            m_idx = 0; m_pos = '0; m_busy = 0; m_done = 0; m_cyc = 0;
        end else begin
            m_cyc++;
            m_done = 0;
            if (!m_busy) begin
                if (start) begin
                    if (mode == 2'b00)      m_idx = m_idx & 6;
                    else if (mode != 2'b10) m_idx = m_idx | 1;
                    if (nsteps == 0) m_done = 1;
                    else begin
                        m_busy = 1; m_t0 = m_cyc; m_n = int'(nsteps); m_k = 0;
                        m_rate = int'(rate_div); m_dir = dir; m_half = (mode == 2'b10);
                    end
                end
            end else if (abort) begin
                m_busy = 0; m_done = 1;
            end else if (((m_cyc - m_t0) % (m_rate + 1)) == 0) begin
                m_idx = (m_idx + 8 + (m_dir ? 1 : -1) * (m_half ? 1 : 2)) % 8;
                m_pos = m_dir ? m_pos + 16'd1 : m_pos - 16'd1;
                m_k++;
                if (m_k == m_n) begin m_busy = 0; m_done = 1; end
            end
        end
    end

    wire [35:0] obs = {motor_drv, busy, done, pos, pos4, motor_drv4, busy4, done4};

    function automatic logic [35:0] exp_vec();
        return {phase_tab[m_idx], m_busy, m_done, m_pos, m_pos[3:0],
                phase_tab[m_idx], m_busy, m_done};
    endfunction

    task automatic do_reset();
        @(negedge drv_clk);
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        @(negedge drv_clk);
        reset = 1'b0;
    endtask

    task automatic launch(input bit d, input logic [1:0] md, input int n, input int rd);
        dir = d; mode = md; nsteps = 16'(n); rate_div = 8'(rd); start = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge drv_clk);
            total++;
            if (obs !== {4'b1000, 1'b0, 1'b0, 16'h0000, 4'h0, 4'b1000, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL reset_idle cyc %0d: got %h want %h", i, obs,
                         {4'b1000, 1'b0, 1'b0, 16'h0000, 4'h0, 4'b1000, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_full_fwd();
        logic [3:0] want_drv [5] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b1100};
        do_reset();
        launch(1'b1, 2'b01, 4, 0);
        for (int i = 0; i < 7; i++) begin
            @(negedge drv_clk);
            start = 1'b0;
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL full_fwd cyc %0d: got %h want %h", i, obs, exp_vec());
            end
            if (i < 5) begin
                total++;
                if (motor_drv !== want_drv[i] || busy !== (i < 4) || done !== (i == 4)) begin
                    bad++;
                    $display("FAIL full_fwd_seq cyc %0d: got %b/%b/%b want %b/%b/%b", i,
                             motor_drv, busy, done, want_drv[i], (i < 4), (i == 4));
                end
            end
        end
        total++;
        if (pos !== 16'd4) begin
            bad++;
            $display("FAIL full_fwd_pos: got %h want 0004", pos);
        end
    endtask

    task automatic test_half_rev();
        do_reset();
        launch(1'b0, 2'b10, 3, 2);
        for (int i = 0; i < 12; i++) begin
            @(negedge drv_clk);
            start = 1'b0;
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL half_rev cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        total++;
        if (pos !== 16'hFFFD || motor_drv !== 4'b0011) begin
            bad++;
            $display("FAIL half_rev_end: got %h/%b want fffd/0011", pos, motor_drv);
        end
    endtask

    task automatic test_wave_abort();
        do_reset();
        launch(1'b1, 2'b00, 10, 1);
        for (int i = 0; i < 9; i++) begin
            @(negedge drv_clk);
            start = 1'b0;
            abort = (i == 4);
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL wave_abort cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        total++;
        if (pos !== 16'd2 || motor_drv !== 4'b0010 || busy !== 1'b0) begin
            bad++;
            $display("FAIL wave_abort_end: got %h/%b/%b want 0002/0010/0", pos, motor_drv, busy);
        end
    endtask

    task automatic test_zero_len();
        launch(1'b1, 2'b10, 0, 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge drv_clk);
            start = 1'b0;
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL zero_len cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        launch(1'b1, 2'b01, 5, 1);
        for (int i = 0; i < 16; i++) begin
            @(negedge drv_clk);
            start = (i == 3);
            dir   = (i < 3);
            mode  = 2'b10;
            if (done) dones++;
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL back_to_back cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL back_to_back_dones: got %0d want 1", dones);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        launch(1'b1, 2'b10, 7, 0);
        for (int i = 0; i < 9; i++) begin
            @(negedge drv_clk);
            start = 1'b0;
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL wrap_to7 cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        launch(1'b1, 2'b10, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge drv_clk);
            start = 1'b0;
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL wrap_step cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        total++;
        if (pos4 !== 4'h8 || pos !== 16'd8 || motor_drv4 !== 4'b1000) begin
            bad++;
            $display("FAIL wrap_end: got %h/%h/%b want 8/0008/1000", pos4, pos, motor_drv4);
        end
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        launch(1'b1, 2'b10, 9, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge drv_clk);
            start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (obs !== {4'b1000, 1'b0, 1'b0, 16'h0000, 4'h0, 4'b1000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_move: got %h want %h", obs,
                     {4'b1000, 1'b0, 1'b0, 16'h0000, 4'h0, 4'b1000, 1'b0, 1'b0});
        end
        @(negedge drv_clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge drv_clk);
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL reset_after cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge drv_clk);
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_vec());
            end
            start    = ($urandom_range(0, 3) == 0);
            dir      = 1'($urandom);
            mode     = 2'($urandom);
            nsteps   = 16'($urandom_range(0, 12));
            rate_div = 8'($urandom_range(0, 3));
            abort    = ($urandom_range(0, 15) == 0);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_fwd();
        test_half_rev();
        test_wave_abort();
        test_zero_len();
        test_back_to_back();
        test_wrap();
        test_reset_mid_move();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
